// File: rtl/recv_protocol.sv
// ---------------------------------------------------------------------------
// recv_protocol
//   Serial frame receiver / deserializer. Hunts the single-bit S_Data line
//   for the sync pattern, shifts in DATA_W payload bits (MSB first), checks
//   the stop bit and presents the payload on RX_Data with a ready/clear
//   handshake toward the consuming core.
//
// Ports
//   clk      : clock, everything sampled on posedge
//   rst      : asynchronous active-high reset
//   S_Data   : serial line, already synchronous to clk
//   clr_rdy  : consumer acknowledge, clears rdy
//   RX_Data  : last good payload (bit DATA_W-1 = first payload bit received)
//   rdy      : level, a good frame is held and not yet acknowledged
//   frm_err  : one-cycle pulse, stop bit sampled as 0
//   ovr      : one-cycle pulse, good frame landed on an unacknowledged one
//   busy     : high whenever the FSM is not hunting for sync
// ---------------------------------------------------------------------------
module recv_protocol #(
    parameter int                 DATA_W   = 55,
    parameter int                 SYNC_W   = 6,
    parameter logic [SYNC_W-1:0]  SYNC_PAT = 6'b011111
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              S_Data,
    input  logic              clr_rdy,
    output logic [DATA_W-1:0] RX_Data,
    output logic              rdy,
    output logic              frm_err,
    output logic              ovr,
    output logic              busy
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        DATA = 2'd1,
        STOP = 2'd2
    } state_t;

    state_t              state_reg,   state_next;
    logic [SYNC_W-1:0]   sync_reg,    sync_next;
    logic [DATA_W-1:0]   shift_reg,   shift_next;
    logic [CNT_W-1:0]    cnt_reg,     cnt_next;
    logic [DATA_W-1:0]   rx_data_reg, rx_data_next;
    logic                rdy_reg,     rdy_next;
    logic                frm_err_reg, frm_err_next;
    logic                ovr_reg,     ovr_next;

    // Window including the bit arriving on this edge, so sync is recognised
    // on the very edge that samples its last bit.
    logic [SYNC_W-1:0]   sync_window;
    assign sync_window = {sync_reg[SYNC_W-2:0], S_Data};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= HUNT;
            sync_reg    <= '1;
            shift_reg   <= '0;
            cnt_reg     <= '0;
            rx_data_reg <= '0;
            rdy_reg     <= 1'b0;
            frm_err_reg <= 1'b0;
            ovr_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            sync_reg    <= sync_next;
            shift_reg   <= shift_next;
            cnt_reg     <= cnt_next;
            rx_data_reg <= rx_data_next;
            rdy_reg     <= rdy_next;
            frm_err_reg <= frm_err_next;
            ovr_reg     <= ovr_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        sync_next    = sync_reg;
        shift_next   = shift_reg;
        cnt_next     = cnt_reg;
        rx_data_next = rx_data_reg;
        // Acknowledge clears rdy; a frame completing on the same edge
        // overrides this below, so set wins.
        rdy_next     = rdy_reg & ~clr_rdy;
        frm_err_next = 1'b0;
        ovr_next     = 1'b0;

        case (state_reg)
            HUNT: begin
                sync_next = sync_window;
                if (sync_window == SYNC_PAT) begin
                    state_next = DATA;
                    cnt_next   = CNT_W'(DATA_W);
                end
            end
            DATA: begin
                // Sync detection is off here, payload may contain SYNC_PAT.
                shift_next = {shift_reg[DATA_W-2:0], S_Data};
                cnt_next   = cnt_reg - 1'b1;
                if (cnt_reg == CNT_W'(1)) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                if (S_Data) begin
                    rx_data_next = shift_reg;
                    rdy_next     = 1'b1;
                    ovr_next     = rdy_reg & ~clr_rdy;
                end else begin
                    frm_err_next = 1'b1;
                end
                state_next = HUNT;
                // All 1s forces a genuine leading 0 before the next match,
                // so the stop bit or a run of 1s cannot false-trigger.
                sync_next  = '1;
            end
            default: begin
                state_next = HUNT;
                sync_next  = '1;
            end
        endcase
    end

    assign RX_Data = rx_data_reg;
    assign rdy     = rdy_reg;
    assign frm_err = frm_err_reg;
    assign ovr     = ovr_reg;
    assign busy    = (state_reg != HUNT);

endmodule
